// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU MEM
// stage and the debug/loader port.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DBG_ACK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: the CPU has priority with zero added
// latency, and the debug port is forced in after STARVE_LIMIT denied cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [DMEM_ADDR_W-1:0] cpu_addr,
  input  logic [DMEM_DATA_W-1:0] cpu_wdata,
  output logic [DMEM_DATA_W-1:0] cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic [DMEM_ADDR_W-1:0] dbg_addr,
  input  logic [DMEM_DATA_W-1:0] dbg_wdata,
  output logic                   dbg_ack,
  output logic [DMEM_DATA_W-1:0] dbg_rdata,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [DMEM_DATA_W-1:0] mem_wdata,
  input  logic [DMEM_DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  ack_q, ack_d;
  logic [DMEM_DATA_W-1:0] dbgRdata_q, dbgRdata_d;
  logic                  grantCpu, grantDbg;

  // Grant decision; nothing is granted while reset is held low.
  always_comb begin
    grantCpu = 1'b0;
    grantDbg = 1'b0;
    if (reset) begin
      if (state_q == ST_DBG_ACK) begin
        grantCpu = cpu_req;
      end else if (dbg_req && (!cpu_req || starve_q == LIMIT_C)) begin
        grantDbg = 1'b1;
      end else begin
        grantCpu = cpu_req;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    if (grantCpu) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
    end else if (grantDbg) begin
      mem_addr  = dbg_addr;
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      mem_wdata = dbg_wdata;
      cpu_stall = cpu_req;
    end
  end

  // Starvation counter only advances while debug is eligible but loses to the CPU.
  always_comb begin
    state_d    = grantDbg ? ST_DBG_ACK : ST_IDLE;
    ack_d      = grantDbg;
    dbgRdata_d = dbgRdata_q;
    starve_d   = starve_q;
    if (grantDbg) begin
      dbgRdata_d = dbg_we ? '0 : mem_rdata;
    end
    if (grantDbg || !dbg_req) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE && cpu_req && starve_q != LIMIT_C) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      ack_q      <= 1'b0;
      dbgRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ack_q      <= ack_d;
      dbgRdata_q <= dbgRdata_d;
    end
  end

  assign dbg_ack   = ack_q;
  assign dbg_rdata = dbgRdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  typedef enum int {G_NONE, G_CPU, G_DBG} grant_t;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [6:0]  cpu_addr, dbg_addr, mem_addr;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_we, mem_re;
  logic        preload;

  logic [31:0] envMem [32];
  logic [31:0] refMem [32];

  int          checks = 0;
  int          errors = 0;
  int          denied;
  bit          ackDue;
  logic [31:0] expDbgRdata;
  grant_t      expGrant;
  logic        ackSeen;
  logic        dbgPending;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seedWord(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 2) return 32'hCAFEF00D;
    return 32'hA5A50000 ^ (i * 32'h01010101);
  endfunction

  // Memory the arbiter drives: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) envMem[i] <= seedWord(i);
    end else if (mem_we) begin
      envMem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = envMem[mem_addr[6:2]];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [6:0] ca,
                               input logic [31:0] cd, input logic dr, input logic dw,
                               input logic [6:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  function automatic grant_t modelGrant();
    if (!reset) return G_NONE;
    if (ackDue) return cpu_req ? G_CPU : G_NONE;
    if (dbg_req && (!cpu_req || denied >= LIMIT)) return G_DBG;
    return cpu_req ? G_CPU : G_NONE;
  endfunction

  task automatic modelReset();
    denied = 0; ackDue = 1'b0; expDbgRdata = '0;
  endtask

  task automatic checkOutput();
    logic [6:0]  eAddr;
    logic        eWe, eRe, eStall;
    logic [31:0] eWd, eRd;
    expGrant = modelGrant();
    eAddr = '0; eWe = 1'b0; eRe = 1'b0; eWd = '0; eRd = '0; eStall = 1'b0;
    if (expGrant == G_CPU) begin
      eAddr = cpu_addr; eWe = cpu_we; eRe = ~cpu_we; eWd = cpu_wdata;
      eRd = refMem[cpu_addr[6:2]];
    end else if (expGrant == G_DBG) begin
      eAddr = dbg_addr; eWe = dbg_we; eRe = ~dbg_we; eWd = dbg_wdata;
      eStall = cpu_req;
    end
    checkVal("mem_addr", {25'd0, mem_addr}, {25'd0, eAddr});
    checkVal("mem_we", {31'd0, mem_we}, {31'd0, eWe});
    checkVal("mem_re", {31'd0, mem_re}, {31'd0, eRe});
    checkVal("mem_wdata", mem_wdata, eWd);
    checkVal("cpu_rdata", cpu_rdata, eRd);
    checkVal("cpu_stall", {31'd0, cpu_stall}, {31'd0, eStall});
    checkVal("dbg_ack", {31'd0, dbg_ack}, {31'd0, ackDue});
    checkVal("dbg_rdata", dbg_rdata, expDbgRdata);
  endtask

  task automatic modelAdvance();
    if (!reset) return;
    if (expGrant == G_DBG) begin
      expDbgRdata = dbg_we ? 32'd0 : refMem[dbg_addr[6:2]];
      if (dbg_we) refMem[dbg_addr[6:2]] = dbg_wdata;
      denied = 0;
      ackDue = 1'b1;
    end else begin
      if (expGrant == G_CPU && cpu_we) refMem[cpu_addr[6:2]] = cpu_wdata;
      if (!dbg_req) denied = 0;
      else if (!ackDue && cpu_req) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
      ackDue = 1'b0;
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge, return just after it.
  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    ackSeen = dbg_ack;
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) refMem[i] = seedWord(i);
    reset = 1'b1; preload = 1'b1; ackSeen = 1'b0; dbgPending = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #2 reset = 1'b0;
    #1;
    checkVal("reset_ack", {31'd0, dbg_ack}, 32'd0);
    checkVal("reset_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1 preload = 1'b0;

    // Requests during reset must not be granted.
    applyStimulus(1, 1, 7'h10, 32'h55, 1, 1, 7'h20, 32'h66);
    stepCycle(); stepCycle();
    reset = 1'b1;

    applyStimulus(1, 0, 7'h10, 0, 0, 0, 0, 0);
    #1;
    checkVal("cpu_load_rdata", cpu_rdata, 32'hDEADBEEF);
    checkVal("cpu_load_stall", {31'd0, cpu_stall}, 32'd0);
    stepCycle();

    applyStimulus(0, 0, 0, 0, 1, 1, 7'h20, 32'h12345678);
    #1 checkVal("dbg_store_we", {31'd0, mem_we}, 32'd1);
    stepCycle();
    #1 checkVal("dbg_store_ack", {31'd0, dbg_ack}, 32'd1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkVal("dbg_store_word", envMem[8], 32'h12345678);

    // Starvation: debug forced in on the fifth contended cycle.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 7'h0C, 0, 1, 0, 7'h04, 0);
      #1;
      checkVal("starve_stall", {31'd0, cpu_stall}, (i == 4) ? 32'd1 : 32'd0);
      checkVal("starve_ack", {31'd0, dbg_ack}, (i == 5) ? 32'd1 : 32'd0);
      stepCycle();
    end

    applyStimulus(1, 1, 7'h08, 32'h11111111, 1, 0, 7'h08, 0);
    #1;
    checkVal("conflict_cpu_we", {31'd0, mem_we}, 32'd1);
    checkVal("conflict_stall", {31'd0, cpu_stall}, 32'd0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 7'h08, 0);
    #1 checkVal("conflict_dbg_re", {31'd0, mem_re}, 32'd1);
    stepCycle();
    #1;
    checkVal("conflict_ack", {31'd0, dbg_ack}, 32'd1);
    checkVal("conflict_rdata", dbg_rdata, 32'h11111111);
    stepCycle();

    // Debug held high continuously: acks alternate.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 7'h10, 0);
      #1 checkVal("b2b_ack", {31'd0, dbg_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Reset landing in the ack cycle discards the ack and the read data.
    applyStimulus(0, 0, 0, 0, 1, 0, 7'h10, 0);
    stepCycle();
    applyStimulus(1, 0, 7'h14, 0, 1, 0, 7'h10, 0);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkVal("midreset_ack", {31'd0, dbg_ack}, 32'd0);
    checkVal("midreset_rdata", dbg_rdata, 32'd0);
    checkVal("midreset_re", {31'd0, mem_re}, 32'd0);
    checkVal("midreset_stall", {31'd0, cpu_stall}, 32'd0);
    stepCycle(); stepCycle();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 0, 7'h10, 0);
    stepCycle(); stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Random traffic with a protocol-respecting debug requester.
    ackSeen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic dwe;
      logic [6:0] dad;
      logic [31:0] dwd;
      if (dbgPending && ackSeen) dbgPending = 1'b0;
      if (!dbgPending && ($urandom % 3 == 0)) begin
        dbgPending = 1'b1;
        dwe = 1'($urandom % 2);
        dad = 7'($urandom_range(0, 127));
        dwd = $urandom;
        dbg_we = dwe; dbg_addr = dad; dbg_wdata = dwd;
      end
      dbg_req   = dbgPending;
      cpu_req   = ($urandom % 4 != 0);
      cpu_we    = 1'($urandom % 2);
      cpu_addr  = 7'($urandom_range(0, 127));
      cpu_wdata = $urandom;
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    for (int i = 0; i < 32; i++) checkVal("final_mem", envMem[i], refMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied debug cycles before debug is forced a grant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  MEM-stage access request (load or store) this cycle.
REQ-005 cpu_we  input  1  1 = store, 0 = load.
REQ-006 cpu_addr  input  7  byte address of 32-bit big-endian word.
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data, valid in the cycle cpu is granted.
REQ-009 cpu_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB this cycle.
REQ-010 dbg_req  input  1  debug/loader request; held with stable fields until dbg_ack.
REQ-011 dbg_we, dbg_addr, dbg_wdata  input  1/7/32  debug write-enable, byte address, write data.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 dbg_rdata  output  32  registered debug load data, valid with dbg_ack.
REQ-014 mem_addr/mem_we/mem_re/mem_wdata  output  7/1/1/32  single-port data-memory access.
REQ-015 mem_rdata  input  32  combinational memory read data for mem_addr.

Function
REQ-016 States: IDLE, DBG_ACK; exactly one grant (cpu, dbg or none) per cycle.
REQ-017 IDLE, cpu_req=1, dbg_req=0 -> grant cpu.
REQ-018 IDLE, dbg_req=1, cpu_req=0 -> grant dbg; next state DBG_ACK.
REQ-019 IDLE, both requesting, starve_cnt < STARVE_LIMIT -> grant cpu; starve_cnt increments.
REQ-020 IDLE, both requesting, starve_cnt == STARVE_LIMIT -> grant dbg; cpu_stall=1 same cycle; next state DBG_ACK.
REQ-021 starve_cnt clears to 0 on any dbg grant or whenever dbg_req=0; saturates at STARVE_LIMIT; width clog2(STARVE_LIMIT+1).
REQ-022 DBG_ACK: dbg_ack=1, dbg_rdata holds word read at grant edge (0 for a debug store); dbg not eligible; cpu granted if cpu_req; next state IDLE unconditionally.
REQ-023 Back-to-back debug: dbg_req high in IDLE after DBG_ACK starts a new transaction; max debug rate one per two cycles.
REQ-024 Grant cpu: mem_addr=cpu_addr, mem_we=cpu_we, mem_re=~cpu_we, mem_wdata=cpu_wdata, cpu_rdata=mem_rdata, cpu_stall=0.
REQ-025 Grant dbg: mem_* driven from dbg_* fields; cpu_stall=cpu_req.
REQ-026 No grant: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0; cpu_rdata=0.
REQ-027 Grant and mux outputs combinational from current state and inputs; zero added latency for cpu accesses.
REQ-028 Addresses pass unmodified; wrap beyond 127 and misalignment are memory's concern.
REQ-029 cpu_stall never asserted when cpu_req=0.

Reset
REQ-030 reset low: state IDLE, starve_cnt 0, dbg_ack 0, dbg_rdata 0 immediately (asynchronous).
REQ-031 While reset low: no grant, mem_we=0, mem_re=0, cpu_stall=0.
REQ-032 Reset mid-debug (in DBG_ACK) discards the ack; debug requester reissues; a store already performed at the grant edge is not undone.
REQ-033 First grant possible on first rising edge after reset deasserts.

Structure
REQ-034 Shared package holds arbiter state enum, DMEM_ADDR_W=7, DMEM_DATA_W=32.
REQ-035 STARVE_LIMIT is a module parameter, not a package constant.
REQ-036 Single module; no sub-modules.

Verification
REQ-037 cpu load addr 0x10, mem holds 0xDEADBEEF, no dbg -> cpu_rdata=0xDEADBEEF same cycle, cpu_stall=0.
REQ-038 dbg store addr 0x20 data 0x12345678, cpu idle -> mem_we=1 cycle N, dbg_ack=1 cycle N+1, memory word 0x20=0x12345678.
REQ-039 cpu_req held high, dbg_req high from cycle 0, STARVE_LIMIT=4 -> cpu granted cycles 0-3, dbg granted cycle 4 with cpu_stall=1, dbg_ack cycle 5.
REQ-040 dbg load addr 0x08 (0xCAFEF00D) concurrent with cpu store addr 0x08 0x11111111, starve_cnt=0 -> cpu wins; dbg wins next free cycle, dbg_rdata=0x11111111.
REQ-041 reset low during DBG_ACK -> dbg_ack, dbg_rdata, starve_cnt 0 immediately; no grant until reset high.
REQ-042 dbg_req held high continuously, cpu idle -> dbg_ack every second cycle, never two consecutive.
